// File: rtl/int_sequencer_if.sv
// Pin, strobe and control bundle between the 6502 datapath/microcode and int_sequencer.
// slave = sequencer side, master = datapath/microcode side.
interface int_sequencer_if;
  logic        nmi_b;
  logic        irq_b;
  logic        i_flag;
  logic        insn_boundary;
  logic        brk;
  logic        busy;
  logic        stack_cycle;
  logic        sp_dec;
  logic        mem_write;
  logic [1:0]  push_sel;
  logic        b_flag;
  logic        vec_rd;
  logic [15:0] vec_addr;
  logic        pcl_load;
  logic        pch_load;
  logic        set_i;
  logic [1:0]  cause;

  modport slave (
    input  nmi_b, irq_b, i_flag, insn_boundary, brk,
    output busy, stack_cycle, sp_dec, mem_write, push_sel, b_flag,
           vec_rd, vec_addr, pcl_load, pch_load, set_i, cause
  );

  modport master (
    output nmi_b, irq_b, i_flag, insn_boundary, brk,
    input  busy, stack_cycle, sp_dec, mem_write, push_sel, b_flag,
           vec_rd, vec_addr, pcl_load, pch_load, set_i, cause
  );
endinterface

// File: rtl/int_sequencer.sv
// Reset/NMI/IRQ/BRK sequencer for the hmc-6502: synchronises pins, arbitrates at boundaries, drives push/vector cycles.
// Optional INT_NMI_HIJACK_EN: an NMI arriving during the pushes of an IRQ/BRK redirects it to the NMI vector.
module int_sequencer #(
  parameter logic [15:0] VEC_NMI = 16'hFFFA,
  parameter logic [15:0] VEC_RES = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic             ph2,
  input  logic             reset,
  int_sequencer_if.slave   bus
);

  typedef enum logic [3:0] {
    S_RST0, S_RST1, S_RST2, S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI
  } state_t;

  localparam logic [1:0] C_RES = 2'd0;
  localparam logic [1:0] C_NMI = 2'd1;
  localparam logic [1:0] C_IRQ = 2'd2;
  localparam logic [1:0] C_BRK = 2'd3;

  logic        r_nmi_s1, r_nmi_s2, r_nmi_prev;
  logic        r_irq_s1, r_irq_s2;
  logic        r_nmi_pending, w_pending_next;
  logic        r_b_flag, w_b_next;
  logic [1:0]  r_cause, w_cause_next;
  state_t      r_state, w_state_next;
  logic        w_nmi_fall, w_irq_req, w_in_push;
  logic [15:0] w_vec;

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_nmi_s1   <= 1'b1;
      r_nmi_s2   <= 1'b1;
      r_nmi_prev <= 1'b1;
      r_irq_s1   <= 1'b1;
      r_irq_s2   <= 1'b1;
    end else begin
      r_nmi_s1   <= bus.nmi_b;
      r_nmi_s2   <= r_nmi_s1;
      r_nmi_prev <= r_nmi_s2;
      r_irq_s1   <= bus.irq_b;
      r_irq_s2   <= r_irq_s1;
    end
  end

  assign w_nmi_fall = r_nmi_prev & ~r_nmi_s2;
  assign w_irq_req  = ~r_irq_s2 & ~bus.i_flag;
  assign w_in_push  = (r_state == S_PUSH_PCH) || (r_state == S_PUSH_PCL) || (r_state == S_PUSH_P);

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RST0;
      r_cause       <= C_RES;
      r_b_flag      <= 1'b0;
      r_nmi_pending <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cause       <= w_cause_next;
      r_b_flag      <= w_b_next;
      r_nmi_pending <= w_pending_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cause_next   = r_cause;
    w_b_next       = r_b_flag;
    w_pending_next = r_nmi_pending;
    case (r_state)
      S_RST0:     w_state_next = S_RST1;
      S_RST1:     w_state_next = S_RST2;
      S_RST2:     w_state_next = S_VEC_LO;
      S_IDLE: begin
        if (bus.insn_boundary) begin
          if (r_nmi_pending) begin
            w_state_next = S_PUSH_PCH;
            w_cause_next = C_NMI;
            w_b_next     = 1'b0;
          end else if (w_irq_req) begin
            w_state_next = S_PUSH_PCH;
            w_cause_next = C_IRQ;
            w_b_next     = 1'b0;
          end else if (bus.brk) begin
            w_state_next = S_PUSH_PCH;
            w_cause_next = C_BRK;
            w_b_next     = 1'b1;
          end
        end
      end
      S_PUSH_PCH: w_state_next = S_PUSH_PCL;
      S_PUSH_PCL: w_state_next = S_PUSH_P;
      S_PUSH_P:   w_state_next = S_VEC_LO;
      S_VEC_LO:   w_state_next = S_VEC_HI;
      S_VEC_HI: begin
        w_state_next = S_IDLE;
        w_b_next     = 1'b0;
      end
      default:    w_state_next = S_RST0;
    endcase
`ifdef INT_NMI_HIJACK_EN
    // b_flag is deliberately left alone so a hijacked BRK still pushes B=1.
    if (w_in_push && (r_cause == C_IRQ || r_cause == C_BRK) && (w_nmi_fall || r_nmi_pending))
      w_cause_next = C_NMI;
`endif
    // A fresh falling edge outranks the clear in the NMI's own VEC_LO cycle.
    if (w_nmi_fall)
      w_pending_next = 1'b1;
    else if (r_state == S_VEC_LO && r_cause == C_NMI)
      w_pending_next = 1'b0;
  end

  always_comb begin
    case (r_cause)
      C_RES:   w_vec = VEC_RES;
      C_NMI:   w_vec = VEC_NMI;
      default: w_vec = VEC_IRQ;
    endcase
  end

  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.stack_cycle = 1'b0;
    bus.sp_dec      = 1'b0;
    bus.mem_write   = 1'b0;
    bus.push_sel    = 2'd0;
    bus.b_flag      = 1'b0;
    bus.vec_rd      = 1'b0;
    bus.vec_addr    = 16'h0000;
    bus.pcl_load    = 1'b0;
    bus.pch_load    = 1'b0;
    bus.set_i       = 1'b0;
    bus.cause       = r_cause;
    case (r_state)
      S_RST0, S_RST1, S_RST2: begin
        bus.stack_cycle = 1'b1;
        bus.sp_dec      = 1'b1;
      end
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
        bus.stack_cycle = 1'b1;
        bus.sp_dec      = 1'b1;
        bus.mem_write   = 1'b1;
        bus.b_flag      = r_b_flag;
        bus.push_sel    = (r_state == S_PUSH_PCH) ? 2'd0 :
                          (r_state == S_PUSH_PCL) ? 2'd1 : 2'd2;
      end
      S_VEC_LO: begin
        bus.vec_rd   = 1'b1;
        bus.vec_addr = w_vec;
        bus.pcl_load = 1'b1;
      end
      S_VEC_HI: begin
        bus.vec_rd   = 1'b1;
        bus.vec_addr = w_vec + 16'd1;
        bus.pch_load = 1'b1;
        bus.set_i    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: per-cycle expected strobe vectors are queued, then popped and compared at negedge.
module tb_int_sequencer;
  logic ph2;
  logic reset;
  int_sequencer_if bus ();

  int_sequencer dut (.ph2(ph2), .reset(reset), .bus(bus));

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  localparam logic [1:0] RES = 2'd0, NMI = 2'd1, IRQ = 2'd2, BRK = 2'd3;

  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];

  function automatic logic [15:0] vec_of(input logic [1:0] c);
    case (c)
      RES:     return 16'hFFFC;
      NMI:     return 16'hFFFA;
      default: return 16'hFFFE;
    endcase
  endfunction

  // {busy, stack, sp_dec, mem_write, push_sel, b_flag, vec_rd, vec_addr, pcl, pch, set_i, cause}
  function automatic logic [28:0] mk(input logic busy, sc, sd, mw, input logic [1:0] ps,
                                     input logic b, vr, input logic [15:0] va,
                                     input logic pl, hl, si, input logic [1:0] c);
    return {busy, sc, sd, mw, ps, b, vr, va, pl, hl, si, c};
  endfunction

  function automatic logic [28:0] f_idle();
    return mk(0, 0, 0, 0, 2'd0, 0, 0, 16'h0, 0, 0, 0, RES);
  endfunction
  function automatic logic [28:0] f_rst();
    return mk(1, 1, 1, 0, 2'd0, 0, 0, 16'h0, 0, 0, 0, RES);
  endfunction
  function automatic logic [28:0] f_push(input logic [1:0] sel, input logic [1:0] c, input logic b);
    return mk(1, 1, 1, 1, sel, b, 0, 16'h0, 0, 0, 0, c);
  endfunction
  function automatic logic [28:0] f_vlo(input logic [1:0] c);
    return mk(1, 0, 0, 0, 2'd0, 0, 1, vec_of(c), 1, 0, 0, c);
  endfunction
  function automatic logic [28:0] f_vhi(input logic [1:0] c);
    return mk(1, 0, 0, 0, 2'd0, 0, 1, vec_of(c) + 16'd1, 0, 1, 1, c);
  endfunction

  function automatic logic [28:0] observed();
    return {bus.busy, bus.stack_cycle, bus.sp_dec, bus.mem_write, bus.push_sel, bus.b_flag,
            bus.vec_rd, bus.vec_addr, bus.pcl_load, bus.pch_load, bus.set_i, bus.cause};
  endfunction

  task automatic check(input string tag);
    logic [28:0] e, o, m;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, observed());
    end else begin
      e = exp_q.pop_front();
      // cause is only meaningful while busy
      m = e[28] ? 29'h1FFF_FFFF : 29'h1FFF_FFFC;
      o = observed() & m;
      assert ((o & m) === (e & m)) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, o, e & m);
      end
      $display("check %0d %s: observed=%h expected=%h", checks, tag, o, e & m);
    end
  endtask

  task automatic cyc(input logic [28:0] e, input string tag);
    exp_q.push_back(e);
    @(negedge ph2);
    check(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(f_idle(), "idle");
  endtask

  // Runs the cycles after the boundary edge of an unhijacked sequence.
  task automatic tail(input logic [1:0] c, input logic b, input string tag);
    bus.insn_boundary = 1'b0;
    bus.brk = 1'b0;
    cyc(f_push(2'd1, c, b), {tag, "_pcl"});
    cyc(f_push(2'd2, c, b), {tag, "_p"});
    cyc(f_vlo(c), {tag, "_vlo"});
    cyc(f_vhi(c), {tag, "_vhi"});
    cyc(f_idle(), {tag, "_done"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.nmi_b = 1'b1; bus.irq_b = 1'b1; bus.i_flag = 1'b1;
    bus.insn_boundary = 1'b0; bus.brk = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 exp_q.push_back(f_rst()); check("reset_async");
    cyc(f_rst(), "reset_held");
    reset = 1'b1;
    cyc(f_rst(), "rst1");
    cyc(f_rst(), "rst2");
    cyc(f_vlo(RES), "rst_vlo");
    cyc(f_vhi(RES), "rst_vhi");
    cyc(f_idle(), "rst_done");

    // Unmasked IRQ; pin released after entry must not abort
    bus.irq_b = 1'b0; bus.i_flag = 1'b0;
    idle(2);
    bus.insn_boundary = 1'b1;
    cyc(f_push(2'd0, IRQ, 0), "irq_pch");
    bus.irq_b = 1'b1;
    tail(IRQ, 0, "irq");

    // Masked IRQ stays idle
    bus.irq_b = 1'b0; bus.i_flag = 1'b1;
    idle(2);
    bus.insn_boundary = 1'b1;
    cyc(f_idle(), "irq_masked");
    bus.insn_boundary = 1'b0;
    bus.irq_b = 1'b1;
    idle(2);

    // brk without boundary ignored, then BRK
    bus.brk = 1'b1;
    cyc(f_idle(), "brk_no_boundary");
    bus.insn_boundary = 1'b1;
    cyc(f_push(2'd0, BRK, 1), "brk_pch");
    tail(BRK, 1, "brk");

    // NMI and IRQ together: NMI wins; held-low NMI does not retrigger
    bus.i_flag = 1'b0; bus.irq_b = 1'b0; bus.nmi_b = 1'b0;
    idle(3);
    bus.insn_boundary = 1'b1;
    cyc(f_push(2'd0, NMI, 0), "nmi_pch");
    tail(NMI, 0, "nmi");
    bus.irq_b = 1'b1;
    idle(2);
    bus.insn_boundary = 1'b1;
    cyc(f_idle(), "nmi_no_repeat");
    bus.insn_boundary = 1'b0;

    // NMI edge becomes pending during PUSH_PCL of a BRK
    bus.nmi_b = 1'b1;
    idle(3);
    bus.brk = 1'b1; bus.insn_boundary = 1'b1; bus.nmi_b = 1'b0;
    cyc(f_push(2'd0, BRK, 1), "hj_pch");
    bus.brk = 1'b0; bus.insn_boundary = 1'b0;
    cyc(f_push(2'd1, BRK, 1), "hj_pcl");
`ifdef INT_NMI_HIJACK_EN
    cyc(f_push(2'd2, NMI, 1), "hj_p");
    cyc(f_vlo(NMI), "hj_vlo");
    cyc(f_vhi(NMI), "hj_vhi");
    cyc(f_idle(), "hj_done");
    bus.insn_boundary = 1'b1;
    cyc(f_idle(), "hj_no_second_nmi");
    bus.insn_boundary = 1'b0;
`else
    cyc(f_push(2'd2, BRK, 1), "hj_p");
    cyc(f_vlo(BRK), "hj_vlo");
    cyc(f_vhi(BRK), "hj_vhi");
    cyc(f_idle(), "hj_done");
    bus.insn_boundary = 1'b1;
    cyc(f_push(2'd0, NMI, 0), "late_nmi_pch");
    tail(NMI, 0, "late_nmi");
`endif

    // Reset mid-sequence with NMI pending discards it
    bus.nmi_b = 1'b1;
    idle(3);
    bus.nmi_b = 1'b0;
    idle(3);
    bus.nmi_b = 1'b1; bus.insn_boundary = 1'b1;
    cyc(f_push(2'd0, NMI, 0), "ra_pch");
    bus.insn_boundary = 1'b0;
    cyc(f_push(2'd1, NMI, 0), "ra_pcl");
    #1 reset = 1'b0;
    #1 exp_q.push_back(f_rst()); check("ra_async_rst0");
    cyc(f_rst(), "ra_held");
    reset = 1'b1;
    cyc(f_rst(), "ra_rst1");
    cyc(f_rst(), "ra_rst2");
    cyc(f_vlo(RES), "ra_vlo");
    cyc(f_vhi(RES), "ra_vhi");
    cyc(f_idle(), "ra_done");
    bus.insn_boundary = 1'b1;
    cyc(f_idle(), "ra_nmi_discarded");
    bus.insn_boundary = 1'b0;
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
